// File: rtl/mux_lanes_tdm.sv
// N-lane time-division byte mux: snapshots all lanes at slot 0, then emits one lane per cycle.
// Build option MUX_IDLE_FILL_EN: invalid slots drive IDLE_CHAR instead of holding data_out.
module mux_lanes_tdm #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] IDLE_CHAR = 32'hBC,
  localparam int unsigned SW       = ($clog2(LANES) > 1) ? $clog2(LANES) : 1
) (
  input  logic                   f2,
  input  logic                   reset_L,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic [LANES-1:0]       valid_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic [SW-1:0]          lane_out,
  output logic                   frame_start
);

  localparam logic [SW-1:0] LAST_SLOT = SW'(LANES - 1);
`ifdef MUX_IDLE_FILL_EN
  localparam logic [WIDTH-1:0] IDLE_W = WIDTH'(IDLE_CHAR);
`endif

  logic [SW-1:0]    r_slot;
  logic [WIDTH-1:0] r_hold_data [LANES];
  logic [LANES-1:0] r_hold_valid;

  logic [WIDTH-1:0] w_word;
  logic             w_valid;

  // Slot 0 bypasses the hold registers so lane 0 leaves on the snapshot edge itself.
  always_comb begin
    w_word  = '0;
    w_valid = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_slot == SW'(i)) begin
        w_word  = r_hold_data[i];
        w_valid = r_hold_valid[i];
      end
    end
    if (r_slot == '0) begin
      w_word  = data_in[WIDTH-1:0];
      w_valid = valid_in[0];
    end
  end

  always_ff @(posedge f2 or negedge reset_L) begin
    if (!reset_L) begin
      r_slot       <= '0;
      r_hold_valid <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        r_hold_data[i] <= '0;
      end
      data_out    <= '0;
      valid_out   <= 1'b0;
      lane_out    <= '0;
      frame_start <= 1'b0;
    end else begin
      r_slot      <= (r_slot == LAST_SLOT) ? '0 : r_slot + SW'(1);
      lane_out    <= r_slot;
      frame_start <= (r_slot == '0);
      if (r_slot == '0) begin
        r_hold_valid <= valid_in;
        for (int unsigned i = 0; i < LANES; i++) begin
          r_hold_data[i] <= data_in[i*WIDTH +: WIDTH];
        end
      end
      valid_out <= w_valid;
      if (w_valid) begin
        data_out <= w_word;
      end else begin
`ifdef MUX_IDLE_FILL_EN
        data_out <= IDLE_W;
`else
        data_out <= data_out;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mux_lanes_tdm.sv
// Directed bench for mux_lanes_tdm: 2-lane vector table, 4-lane and 3-lane cadence, mid-frame reset.
module tb_mux_lanes_tdm;

  logic f2 = 1'b0;
  logic reset_L;
  always #5 f2 = ~f2;

  logic [15:0] d2_in;  logic [1:0] d2_vin;
  logic [7:0]  d2_out; logic d2_v; logic [0:0] d2_lane; logic d2_fs;
  logic [63:0] d4_in;  logic [3:0] d4_vin;
  logic [15:0] d4_out; logic d4_v; logic [1:0] d4_lane; logic d4_fs;
  logic [23:0] d3_in;  logic [2:0] d3_vin;
  logic [7:0]  d3_out; logic d3_v; logic [1:0] d3_lane; logic d3_fs;

  mux_lanes_tdm #(.LANES(2), .WIDTH(8)) u_d2 (
    .f2(f2), .reset_L(reset_L), .data_in(d2_in), .valid_in(d2_vin),
    .data_out(d2_out), .valid_out(d2_v), .lane_out(d2_lane), .frame_start(d2_fs));
  mux_lanes_tdm #(.LANES(4), .WIDTH(16)) u_d4 (
    .f2(f2), .reset_L(reset_L), .data_in(d4_in), .valid_in(d4_vin),
    .data_out(d4_out), .valid_out(d4_v), .lane_out(d4_lane), .frame_start(d4_fs));
  mux_lanes_tdm #(.LANES(3), .WIDTH(8)) u_d3 (
    .f2(f2), .reset_L(reset_L), .data_in(d3_in), .valid_in(d3_vin),
    .data_out(d3_out), .valid_out(d3_v), .lane_out(d3_lane), .frame_start(d3_fs));

  typedef struct {
    logic [15:0] din;
    logic [1:0]  vin;
    logic [7:0]  ed;
    logic        ev;
    logic        el;
    logic        efs;
  } vec_t;

  vec_t tbl [8];
  int total = 0;
  int bad = 0;
  logic [7:0] idle_exp;

  task automatic tick();
    @(posedge f2);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (data,valid,lane,fs packed)", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
`ifdef MUX_IDLE_FILL_EN
    idle_exp = 8'hBC;
`else
    idle_exp = 8'h63;
`endif
    tbl[0] = '{16'h8124, 2'b11, 8'h24,    1'b1, 1'b0, 1'b1};
    tbl[1] = '{16'hFFFF, 2'b11, 8'h81,    1'b1, 1'b1, 1'b0};
    tbl[2] = '{16'h0963, 2'b01, 8'h63,    1'b1, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFF, 2'b11, idle_exp, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h5AA5, 2'b10, idle_exp, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{16'h0000, 2'b00, 8'h5A,    1'b1, 1'b1, 1'b0};
    tbl[6] = '{16'h1122, 2'b11, 8'h22,    1'b1, 1'b0, 1'b1};
    tbl[7] = '{16'h3344, 2'b00, 8'h11,    1'b1, 1'b1, 1'b0};

    // Reset held with random inputs: everything stays cleared.
    reset_L = 1'b0;
    d4_in = '0; d4_vin = '0; d3_in = '0; d3_vin = '0;
    for (int c = 0; c < 2; c++) begin
      d2_in = 16'($urandom); d2_vin = 2'($urandom);
      d4_in = {$urandom, $urandom}; d4_vin = 4'($urandom);
      d3_in = 24'($urandom); d3_vin = 3'($urandom);
      tick();
      chk("reset_d2", {d2_out, d2_v, d2_lane, d2_fs}, 32'h0);
      chk("reset_d4", {d4_out, d4_v, d4_lane, d4_fs}, 32'h0);
      chk("reset_d3", {d3_out, d3_v, d3_lane, d3_fs}, 32'h0);
    end
    reset_L = 1'b1;

    for (int i = 0; i < 8; i++) begin
      d2_in = tbl[i].din;
      d2_vin = tbl[i].vin;
      tick();
      chk($sformatf("vec%0d", i), {d2_out, d2_v, d2_lane, d2_fs},
          {tbl[i].ed, tbl[i].ev, tbl[i].el, tbl[i].efs});
    end

    // Four lanes, three frames; off-frame inputs are garbage and must be ignored.
    pulse_reset();
    for (int c = 0; c < 12; c++) begin
      if (c % 4 == 0) begin
        for (int k = 0; k < 4; k++) d4_in[k*16 +: 16] = 16'hA000 + 16'((c / 4) * 256 + k * 17);
        d4_vin = 4'hF;
      end else begin
        d4_in = {4{16'hDEAD}};
        d4_vin = 4'h0;
      end
      tick();
      chk($sformatf("lanes4_c%0d", c), {d4_out, d4_v, d4_lane, d4_fs},
          {16'hA000 + 16'((c / 4) * 256 + (c % 4) * 17), 1'b1, 2'(c % 4), 1'(c % 4 == 0)});
    end

    // Three lanes: slot wraps 2 -> 0, lane 3 never appears.
    pulse_reset();
    for (int c = 0; c < 7; c++) begin
      if (c % 3 == 0) begin
        for (int k = 0; k < 3; k++) d3_in[k*8 +: 8] = 8'h30 + 8'((c / 3) * 3 + k);
        d3_vin = 3'b111;
      end else begin
        d3_in = 24'hEEEEEE;
        d3_vin = 3'b000;
      end
      tick();
      chk($sformatf("lanes3_c%0d", c), {d3_out, d3_v, d3_lane, d3_fs},
          {8'h30 + 8'((c / 3) * 3 + (c % 3)), 1'b1, 2'(c % 3), 1'(c % 3 == 0)});
    end

    // Mid-frame asynchronous reset while lane_out==1.
    pulse_reset();
    d2_in = 16'h1234; d2_vin = 2'b11;
    tick();
    chk("pre_rst_lane0", {d2_out, d2_v, d2_lane, d2_fs}, {8'h34, 1'b1, 1'b0, 1'b1});
    d2_in = 16'hFFFF;
    tick();
    chk("pre_rst_lane1", {d2_out, d2_v, d2_lane, d2_fs}, {8'h12, 1'b1, 1'b1, 1'b0});
    #2 reset_L = 1'b0;
    #1 chk("async_clear", {d2_out, d2_v, d2_lane, d2_fs}, 32'h0);
    tick();
    chk("reset_hold", {d2_out, d2_v, d2_lane, d2_fs}, 32'h0);
    reset_L = 1'b1;
    d2_in = 16'h7766; d2_vin = 2'b11;
    tick();
    chk("post_rst_lane0", {d2_out, d2_v, d2_lane, d2_fs}, {8'h66, 1'b1, 1'b0, 1'b1});
    d2_in = 16'h0000; d2_vin = 2'b00;
    tick();
    chk("post_rst_lane1", {d2_out, d2_v, d2_lane, d2_fs}, {8'h77, 1'b1, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
